uriscv_muldiv: RTL and testbench
================================

Name: uriscv_muldiv

Overview:
- Iterative RV32M multiply/divide unit, the multi-cycle counterpart to the single-cycle integer ALU.
- Sits beside the ALU in the execute stage. The core issues an op with operands, stalls until the result returns, then writes it back.
- One shared 32-iteration shift datapath serves both multiply (shift-add) and divide (restoring).

Parameters:
- SUPPORT_MUL, 1: 0 removes the multiply path; MUL* ops then complete on the fast path with result 0.
- SUPPORT_DIV, 1: 0 removes the divide path; DIV*/REM* ops then complete on the fast path with result 0.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  request valid.
- op_i  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  32  operand rs1.
- b_i  in  32  operand rs2.
- flush_i  in  1  abort any in-flight op.
- ready_o  out  1  unit can accept a request.
- valid_o  out  1  result valid; one-cycle pulse.
- p_o  out  32  result.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, ready_o=1, valid_o=0, p_o=0, counter=0, datapath registers 0.
- ready_o = (state==IDLE), combinational from state.
- accept = valid_i & ready_o & ~flush_i. Operands and op are captured on the accepting edge (E0).
- States:
  - IDLE: on accept go to RUN, or to DONE if the fast path applies.
  - RUN: performs one iteration per edge. After 32 iterations (edges E1..E32) go to DONE.
  - DONE: valid_o=1 for exactly one cycle, then go to IDLE.
- Normal latency:
  - valid_o is high in the cycle after E32.
  - ready_o returns after E33.
  - Earliest next accept is E34.
- Fast path (E0 goes directly to DONE; valid_o is high in the cycle after E0):
  - DIV/DIVU with b=0: quotient 0xFFFFFFFF.
  - REM/REMU with b=0: result = a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
  - Any op disabled by its parameter.
- Multiply:
  - Operand magnitudes: a is signed for MUL, MULH and MULHSU; b is signed for MUL and MULH only.
  - Forms a 64-bit unsigned product by shift-add over 32 iterations.
  - Negates the product if the operand signs differ.
  - MUL returns bits [31:0]; the others return [63:32].
- Divide:
  - Restoring division on magnitudes (signed for DIV/REM), 1 quotient bit per iteration.
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
- p_o updates only on entry to DONE and holds its value until the next result, including through flush.
- flush_i:
  - In RUN or DONE: next state IDLE, valid_o forced 0 that cycle, p_o unchanged.
  - In IDLE with valid_i: request is not accepted.
- Inputs other than flush_i are ignored while not IDLE; the core holds them but the unit does not re-sample.
- Reset asserted mid-operation: immediate return to reset values; no valid_o pulse.
- Width rules:
  - Partial-remainder subtract is 33 bits wide.
  - Product accumulator is 64 bits with a carry-out bit.
  - Counter is 5 bits with a terminal flag; no wrap ambiguity.

Decomposition:
- Shared package/defs include: funct3 op encodings (RV_MD_MUL..RV_MD_REMU), state encodings (MD_IDLE, MD_RUN, MD_DONE), iteration count constant MD_ITERS=32.
- Sub-module uriscv_muldiv_core: the 64-bit shift register plus 33-bit add/subtract step; combinational, one iteration per call.
- The top level holds the FSM, counter, sign fix-up and fast-path logic.

Test Plan:
- MUL a=7, b=6: valid_o exactly 33 cycles after accept, p_o=42; ready_o low for 33 cycles, high after.
- MULH a=0x80000000, b=0x80000000 -> p_o=0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- Signed divide with a=0xFFFFFFF9 (-7), b=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU a=100, b=7 -> 14.
  - REMU a=100, b=7 -> 2.
- Fast path:
  - DIV a=5, b=0 -> 0xFFFFFFFF one cycle after accept.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush and reset mid-operation:
  - Accept DIVU, assert flush_i 10 cycles later: no valid_o, ready_o high next cycle, p_o unchanged.
  - New MUL 3×4 then returns 12.
  - Async reset mid-RUN: outputs go to reset values immediately, without waiting for a clock edge.
- Back-to-back random stream of 1000 ops with valid_i held high: every result matches the reference model, and accepts are spaced at 34 cycles (normal) or 2 cycles (fast path).

Source files
------------

// File: rtl/uriscv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and iteration constants.
package uriscv_muldiv_pkg;

   localparam int XLEN     = 32;
   localparam int MD_ITERS = 32;
   localparam int CNT_W    = 5;

   typedef enum logic [2:0] {
      RV_MD_MUL    = 3'd0,
      RV_MD_MULH   = 3'd1,
      RV_MD_MULHSU = 3'd2,
      RV_MD_MULHU  = 3'd3,
      RV_MD_DIV    = 3'd4,
      RV_MD_DIVU   = 3'd5,
      RV_MD_REM    = 3'd6,
      RV_MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (XLEN'(0) - v) : v;
   endfunction

endpackage

// File: rtl/uriscv_muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
interface uriscv_muldiv_if;
   import uriscv_muldiv_pkg::*;

   logic            valid_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            ready_o;
   logic            valid_o;
   logic [XLEN-1:0] p_o;

   modport master (output valid_i, op_i, a_i, b_i, flush_i,
                   input  ready_o, valid_o, p_o);
   modport slave  (input  valid_i, op_i, a_i, b_i, flush_i,
                   output ready_o, valid_o, p_o);
endinterface

// File: rtl/uriscv_muldiv_core.sv
// One iteration of the shared 64-bit shift datapath: shift-add multiply step
// or restoring divide step, selected by is_div.
module uriscv_muldiv_core
   import uriscv_muldiv_pkg::*;
#(
   parameter bit SUPPORT_MUL = 1'b1,
   parameter bit SUPPORT_DIV = 1'b1
) (
   input  logic            is_div,
   input  logic [63:0]     acc,
   input  logic [XLEN-1:0] opnd,
   output logic [63:0]     acc_nxt
);

   logic [32:0] sum;
   logic [32:0] sh;
   logic [32:0] diff;
   logic        ge;
   logic        unused_diff_msb;

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set.
   assign sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

   // Divide: shifted partial remainder always fits in 32 bits after a successful subtract.
   assign sh   = {acc[63:32], acc[31]};
   assign ge   = (sh >= {1'b0, opnd});
   assign diff = sh - {1'b0, opnd};
   assign unused_diff_msb = diff[32];

   always_comb begin
      acc_nxt = acc;
      if (is_div) begin
         if (SUPPORT_DIV)
            acc_nxt = {(ge ? diff[31:0] : sh[31:0]), acc[30:0], ge};
      end else if (SUPPORT_MUL) begin
         acc_nxt = {sum, acc[31:1]};
      end
   end

endmodule

// File: rtl/uriscv_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, operand
// magnitude/sign handling and the divide-by-zero / overflow fast path.
//
// state   | meaning
// MD_IDLE | ready for a request; ready_o high
// MD_RUN  | 32 datapath iterations, one per edge
// MD_DONE | result on p_o, valid_o pulses for this cycle
module uriscv_muldiv
   import uriscv_muldiv_pkg::*;
#(
   parameter bit SUPPORT_MUL = 1'b1,
   parameter bit SUPPORT_DIV = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   uriscv_muldiv_if.slave bus
);

   md_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic            cnt_tc;
   logic [63:0]     acc, acc_nxt;
   logic [XLEN-1:0] opnd;
   logic [XLEN-1:0] p_q;
   logic [2:0]      op_q;
   logic            neg_q;

   logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_by0, div_ovf, disabled, fast;
   logic [XLEN-1:0] fast_res;
   logic [63:0]     prod;
   logic [XLEN-1:0] div_raw, run_res;

   assign cnt_tc      = (cnt == '0);
   assign accept      = bus.valid_i & (state == MD_IDLE) & ~bus.flush_i;
   assign bus.ready_o = (state == MD_IDLE);
   assign bus.valid_o = (state == MD_DONE) & ~bus.flush_i;
   assign bus.p_o     = p_q;

   always_comb begin
      is_div = bus.op_i[2];
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      if (is_div) begin
         a_sgn = ~bus.op_i[0];
         b_sgn = ~bus.op_i[0];
      end else begin
         a_sgn = (bus.op_i[1:0] != 2'b11);
         b_sgn = ~bus.op_i[1];
      end
      a_neg = a_sgn & bus.a_i[31];
      b_neg = b_sgn & bus.b_i[31];
      a_mag = md_mag(bus.a_i, a_neg);
      b_mag = md_mag(bus.b_i, b_neg);
   end

   always_comb begin
      div_by0  = is_div & (bus.b_i == '0);
      div_ovf  = is_div & ~bus.op_i[0] & (bus.a_i == 32'h8000_0000) & (bus.b_i == 32'hFFFF_FFFF);
      disabled = is_div ? !SUPPORT_DIV : !SUPPORT_MUL;
      fast     = disabled | div_by0 | div_ovf;
      fast_res = '0;
      if (disabled)
         fast_res = '0;
      else if (div_by0)
         fast_res = bus.op_i[1] ? bus.a_i : 32'hFFFF_FFFF;
      else if (div_ovf)
         fast_res = bus.op_i[1] ? 32'h0 : 32'h8000_0000;
   end

   uriscv_muldiv_core #(
      .SUPPORT_MUL (SUPPORT_MUL),
      .SUPPORT_DIV (SUPPORT_DIV)
   ) u_core (
      .is_div  (op_q[2]),
      .acc     (acc),
      .opnd    (opnd),
      .acc_nxt (acc_nxt)
   );

   // Sign fix-up applied to the value the final iteration produces.
   always_comb begin
      prod    = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
      div_raw = op_q[1] ? acc_nxt[63:32] : acc_nxt[31:0];
      if (op_q[2])
         run_res = md_mag(div_raw, neg_q);
      else
         run_res = (op_q == RV_MD_MUL) ? prod[31:0] : prod[63:32];
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         state <= MD_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_RUN;
         MD_RUN: begin
            if (bus.flush_i)
               state_nxt = MD_IDLE;
            else if (cnt_tc)
               state_nxt = MD_DONE;
         end
         MD_DONE: state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         p_q   <= '0;
      end else if (accept) begin
         op_q  <= bus.op_i;
         neg_q <= (is_div & bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
         acc   <= {32'd0, (is_div ? a_mag : b_mag)};
         opnd  <= is_div ? b_mag : a_mag;
         cnt   <= CNT_W'(MD_ITERS - 1);
         if (fast)
            p_q <= fast_res;
      end else if ((state == MD_RUN) && !bus.flush_i) begin
         acc <= acc_nxt;
         if (cnt_tc)
            p_q <= run_res;
         else
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_uriscv_muldiv.sv
// Self-checking bench for uriscv_muldiv: arithmetic reference model with a
// cycle-level handshake model, directed vectors and a back-to-back random stream.
module tb_uriscv_muldiv;
   import uriscv_muldiv_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   uriscv_muldiv_if bus_if ();

   uriscv_muldiv #(
      .SUPPORT_MUL (1'b1),
      .SUPPORT_DIV (1'b1)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus_if)
   );

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = $signed(a);
      sb = $signed(b);
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 0) return 1'b1;
      return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Handshake model: m_left counts edges still needed before the result is shown.
   bit          m_busy    = 1'b0;
   int          m_left    = 0;
   logic [31:0] m_res     = '0;
   logic [31:0] m_p       = '0;
   int          m_acc_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_left = 0;
         m_p    = '0;
      end else if (!m_busy) begin
         if (bus_if.valid_i && !bus_if.flush_i) begin
            m_busy = 1'b1;
            m_acc_cnt++;
            m_res  = ref_md(bus_if.op_i, bus_if.a_i, bus_if.b_i);
            m_left = ref_fast(bus_if.op_i, bus_if.a_i, bus_if.b_i) ? 0 : MD_ITERS;
            if (m_left == 0) m_p = m_res;
         end
      end else if (bus_if.flush_i) begin
         m_busy = 1'b0;
      end else if (m_left == 0) begin
         m_busy = 1'b0;
      end else begin
         m_left--;
         if (m_left == 0) m_p = m_res;
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", {31'd0, bus_if.ready_o}, {31'd0, !m_busy});
         check("valid", {31'd0, bus_if.valid_o}, {31'd0, (m_busy && m_left == 0 && !bus_if.flush_i)});
         check("p", bus_if.p_o, m_p);
      end
   end

   // Call at #1 after a posedge with the unit idle; returns at #1 after the edge leaving DONE.
   task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k;
      bit seen;
      check({name, "_model"}, ref_md(op, a, b), exp);
      bus_if.valid_i = 1'b1;
      bus_if.op_i    = op;
      bus_if.a_i     = a;
      bus_if.b_i     = b;
      @(posedge clk);
      #1 bus_if.valid_i = 1'b0;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (bus_if.valid_o) seen = 1'b1;
      end
      check({name, "_lat"}, k, lat);
      check({name, "_p"}, bus_if.p_o, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          base, k;

      bus_if.valid_i = 1'b0;
      bus_if.op_i    = '0;
      bus_if.a_i     = '0;
      bus_if.b_i     = '0;
      bus_if.flush_i = 1'b0;

      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, bus_if.ready_o}, 32'd1);
      check("rst_valid", {31'd0, bus_if.valid_o}, 32'd0);
      check("rst_p", bus_if.p_o, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;

      do_op("mul_7x6",   3'd0, 32'd7,         32'd6,         32'd42,        33);
      do_op("mulh",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      do_op("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      do_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      do_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      do_op("divu_100",  3'd5, 32'd100,       32'd7,         32'd14,        33);
      do_op("div_by0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      do_op("remu_by0",  3'd7, 32'd5,         32'd0,         32'd5,         1);
      do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      do_op("remu_100",  3'd7, 32'd100,       32'd7,         32'd2,         33);

      // Flush ten cycles into a DIVU: no result, unit idle again, p_o kept.
      bus_if.valid_i = 1'b1;
      bus_if.op_i    = 3'd5;
      bus_if.a_i     = 32'd1000;
      bus_if.b_i     = 32'd3;
      @(posedge clk);
      #1 bus_if.valid_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 bus_if.flush_i = 1'b1;
      @(negedge clk);
      check("flush_valid", {31'd0, bus_if.valid_o}, 32'd0);
      @(posedge clk);
      #1 bus_if.flush_i = 1'b0;
      @(negedge clk);
      check("flush_ready", {31'd0, bus_if.ready_o}, 32'd1);
      check("flush_p", bus_if.p_o, 32'd2);
      @(posedge clk);
      #1;
      do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

      // Request presented together with flush in IDLE is dropped.
      bus_if.valid_i = 1'b1;
      bus_if.flush_i = 1'b1;
      bus_if.op_i    = 3'd0;
      bus_if.a_i     = 32'd5;
      bus_if.b_i     = 32'd5;
      @(posedge clk);
      #1;
      bus_if.valid_i = 1'b0;
      bus_if.flush_i = 1'b0;
      @(negedge clk);
      check("idle_flush_ready", {31'd0, bus_if.ready_o}, 32'd1);
      check("idle_flush_p", bus_if.p_o, 32'd12);
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of RUN, checked before any further clock edge.
      bus_if.valid_i = 1'b1;
      bus_if.op_i    = 3'd0;
      bus_if.a_i     = 32'd9;
      bus_if.b_i     = 32'd9;
      @(posedge clk);
      #1 bus_if.valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, bus_if.ready_o}, 32'd1);
      check("arst_valid", {31'd0, bus_if.valid_o}, 32'd0);
      check("arst_p", bus_if.p_o, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back stream with valid_i held high; new operands once each accept happens.
      bus_if.valid_i = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         rop = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: begin ra = $urandom; rb = 32'd0; end
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         bus_if.op_i = rop;
         bus_if.a_i  = ra;
         bus_if.b_i  = rb;
         base = m_acc_cnt;
         k    = 0;
         while (m_acc_cnt == base && k < 50) begin
            @(posedge clk);
            #1;
            k++;
         end
         if (m_acc_cnt == base) begin
            check("stream_accept", 32'd0, 32'd1);
            break;
         end
      end
      bus_if.valid_i = 1'b0;
      k = 0;
      while (m_busy && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (2) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
